video_frame_aligner: RTL

- Upstream neighbour of the median filter; sits between the video source and the filter's video_i input.
- Guarantees every outgoing frame is exactly FRAME_RES_X x FRAME_RES_Y pixels, with tuser=SOF on the first pixel and tlast=EOL on every line.
- Repairs malformed frames: pads short lines, truncates long lines, pads early-terminated frames, drops pre-SOF garbage.
- Inserts INTERLINE_GAP idle cycles after each line so the line-buffer filter always has its compensation slots.

---
 rtl/video_frame_aligner_pkg.sv | 24 ++
 rtl/video_frame_aligner_if.sv | 14 +
 rtl/video_frame_aligner_out_reg.sv | 48 ++++
 rtl/video_frame_aligner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/video_frame_aligner_pkg.sv
// video_frame_aligner_pkg: shared FSM state type and sizing helpers for the
// video frame aligner.
package video_frame_aligner_pkg;

  typedef enum logic [2:0] {
    WAIT_SOF,
    PASS,
    DROP_LINE,
    PAD_LINE,
    PAD_FRAME,
    GAP
  } state_t;

  // Counter width for a 0..max-1 counter: one spare bit over $clog2(max).
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

  // 16-bit saturating increment used by the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic hit);
    return (hit && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/video_frame_aligner_if.sv
// video_frame_aligner_if: AXI4-Stream video bundle (tdata/tvalid/tlast/tuser/
// tready). The master drives the beat, the slave drives tready.
interface video_frame_aligner_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tuser;
  logic                   tready;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/video_frame_aligner_out_reg.sv
// video_frame_aligner_out_reg: one-entry output stage. Every emit path of the
// aligner (forwarded pixels and pad pixels) goes through this register; the
// beat is held stable while the downstream stalls.
module video_frame_aligner_out_reg #(
  parameter int TDATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  logic [TDATA_WIDTH-1:0] din,
  input  logic                   lin,
  input  logic                   uin,
  output logic                   free,
  output logic                   full,
  video_frame_aligner_if.master  video_o
);
  logic                   vld;
  logic [TDATA_WIDTH-1:0] data;
  logic                   last;
  logic                   user;

  // Loadable when empty or when the current beat leaves this cycle.
  assign free = !vld || video_o.tready;
  assign full = vld;

  // Register load: push is only honoured when the slot is free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld  <= 1'b0;
      data <= '0;
      last <= 1'b0;
      user <= 1'b0;
    end else if (free) begin
      vld <= push;
      if (push) begin
        data <= din;
        last <= lin;
        user <= uin;
      end
    end
  end

  assign video_o.tvalid = vld;
  assign video_o.tdata  = data;
  assign video_o.tlast  = last;
  assign video_o.tuser  = user;

endmodule

// File: rtl/video_frame_aligner.sv
// video_frame_aligner: forces every outgoing frame to FRAME_RES_X x
// FRAME_RES_Y pixels with SOF on the first pixel and EOL on each line,
// padding short lines/frames, truncating long lines, dropping pre-SOF beats,
// and inserting INTERLINE_GAP idle cycles after each output line.
// Optional statistics counters: define VIDEO_FRAME_ALIGNER_STAT_EN.
// Assumes FRAME_RES_X >= 2 and FRAME_RES_Y >= 1.
module video_frame_aligner
  import video_frame_aligner_pkg::*;
#(
  parameter int                     TDATA_WIDTH   = 32,
  parameter int                     FRAME_RES_X   = 1920,
  parameter int                     FRAME_RES_Y   = 1080,
  parameter int                     INTERLINE_GAP = 100,
  parameter logic [TDATA_WIDTH-1:0] PAD_VALUE     = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  video_frame_aligner_if.slave  video_i,
  video_frame_aligner_if.master video_o,
  output logic                  err_short_o,
  output logic                  err_long_o,
  output logic                  err_sof_o
`ifdef VIDEO_FRAME_ALIGNER_STAT_EN
  ,
  input  logic                  stat_clr_i,
  output logic [15:0]           stat_short_o,
  output logic [15:0]           stat_long_o,
  output logic [15:0]           stat_sof_o,
  output logic [15:0]           stat_frames_o
`endif
);
  localparam int PX_W = cnt_w(FRAME_RES_X);
  localparam int LN_W = cnt_w(FRAME_RES_Y);
  localparam int GP_W = cnt_w(INTERLINE_GAP);
  localparam logic [PX_W-1:0] PX_MAX = PX_W'(FRAME_RES_X - 1);
  localparam logic [LN_W-1:0] LN_MAX = LN_W'(FRAME_RES_Y - 1);
  localparam logic [GP_W-1:0] GP_MAX = GP_W'(INTERLINE_GAP - 1);
  localparam bit              HAS_GAP = (INTERLINE_GAP != 0);

  state_t                 state, state_n;
  logic                   pad_mode, pad_n;
  logic [PX_W-1:0]        px_cnt;
  logic [LN_W-1:0]        ln_cnt;
  logic [GP_W-1:0]        gap_cnt;

  logic                   push, p_last, p_user;
  logic [TDATA_WIDTH-1:0] p_data;
  logic                   free, full;
  logic                   in_ready;
  logic                   err_s, err_l, err_f;
  logic                   px_last, ln_last, origin;
  state_t                 eol_tgt, post_eol;

  assign px_last = (px_cnt == PX_MAX);
  assign ln_last = (ln_cnt == LN_MAX);
  assign origin  = (px_cnt == '0) && (ln_cnt == '0);

  // Where to go once an EOL beat is pushed this cycle (counters not yet advanced).
  assign eol_tgt  = ln_last ? WAIT_SOF : (pad_mode ? PAD_FRAME : PASS);
  // Where to go after a line that already advanced the counters (ln wrapped = frame done).
  assign post_eol = (ln_cnt == '0) ? WAIT_SOF : (pad_mode ? PAD_FRAME : PASS);

  // State, mode and position counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= WAIT_SOF;
      pad_mode <= 1'b0;
      px_cnt   <= '0;
      ln_cnt   <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_n;
      pad_mode <= pad_n;
      if (push) begin
        if (px_last) begin
          px_cnt <= '0;
          ln_cnt <= ln_last ? '0 : ln_cnt + LN_W'(1);
        end else begin
          px_cnt <= px_cnt + PX_W'(1);
        end
      end
      // Gap cycles only count once the EOL beat has left the output register.
      if (state == GAP && !full)
        gap_cnt <= (gap_cnt == GP_MAX) ? '0 : gap_cnt + GP_W'(1);
    end
  end

  // Next state, input ready, emit request and error detection.
  always_comb begin
    state_n  = state;
    pad_n    = pad_mode;
    push     = 1'b0;
    p_data   = video_i.tdata;
    p_last   = 1'b0;
    p_user   = 1'b0;
    in_ready = 1'b0;
    err_s    = 1'b0;
    err_l    = 1'b0;
    err_f    = 1'b0;
    case (state)
      WAIT_SOF: begin
        // The register is always empty here when a gap precedes this state,
        // so ready reads as 1; it only drops if INTERLINE_GAP=0 and the
        // last EOL is still stalled downstream.
        in_ready = free;
        pad_n    = 1'b0;
        if (video_i.tvalid && video_i.tuser && free) begin
          push    = 1'b1;
          p_user  = 1'b1;
          state_n = PASS;
        end
      end
      PASS: begin
        if (video_i.tvalid && video_i.tuser && !origin) begin
          // Premature SOF: leave the beat pending for WAIT_SOF.
          err_f   = 1'b1;
          pad_n   = 1'b1;
          state_n = PAD_FRAME;
        end else begin
          in_ready = free;
          if (video_i.tvalid && free) begin
            push   = 1'b1;
            p_user = origin;
            p_last = px_last;
            if (video_i.tlast && !px_last) begin
              err_s   = 1'b1;
              state_n = PAD_LINE;
            end else if (px_last && !video_i.tlast) begin
              err_l   = 1'b1;
              state_n = DROP_LINE;
            end else if (px_last) begin
              state_n = HAS_GAP ? GAP : eol_tgt;
            end
          end
        end
      end
      DROP_LINE: begin
        if (video_i.tvalid && video_i.tuser) begin
          // The truncated line already emitted its EOL, so px_cnt is 0 here.
          // An SOF is premature only if the frame still lacks lines; either
          // way the gap owed to the truncated line is still inserted.
          err_f   = (ln_cnt != '0);
          pad_n   = (ln_cnt != '0);
          state_n = HAS_GAP ? GAP : ((ln_cnt == '0) ? WAIT_SOF : PAD_FRAME);
        end else begin
          in_ready = 1'b1;
          if (video_i.tvalid && video_i.tlast)
            state_n = HAS_GAP ? GAP : post_eol;
        end
      end
      PAD_LINE, PAD_FRAME: begin
        if (free) begin
          push   = 1'b1;
          p_data = PAD_VALUE;
          p_last = px_last;
          if (px_last)
            state_n = HAS_GAP ? GAP : eol_tgt;
        end
      end
      GAP: begin
        if (!full && gap_cnt == GP_MAX)
          state_n = post_eol;
      end
      default: state_n = WAIT_SOF;
    endcase
  end

  video_frame_aligner_out_reg #(
    .TDATA_WIDTH (TDATA_WIDTH)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (push),
    .din     (p_data),
    .lin     (p_last),
    .uin     (p_user),
    .free    (free),
    .full    (full),
    .video_o (video_o)
  );

  // Combinational outputs are forced low while reset is held.
  assign video_i.tready = in_ready && !rst_i;
  assign err_short_o    = err_s && !rst_i;
  assign err_long_o     = err_l && !rst_i;
  assign err_sof_o      = err_f && !rst_i;

`ifdef VIDEO_FRAME_ALIGNER_STAT_EN
  logic frame_done;
  assign frame_done = push && px_last && ln_last;

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || stat_clr_i) begin
      stat_short_o  <= '0;
      stat_long_o   <= '0;
      stat_sof_o    <= '0;
      stat_frames_o <= '0;
    end else begin
      stat_short_o  <= sat_inc(stat_short_o, err_s);
      stat_long_o   <= sat_inc(stat_long_o, err_l);
      stat_sof_o    <= sat_inc(stat_sof_o, err_f);
      stat_frames_o <= sat_inc(stat_frames_o, frame_done);
    end
  end
`endif

endmodule
